// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions for the receive and transmit sides.
//   CLKS_PER_BIT_DEFAULT : baud divisor for 115200 baud from a 50 MHz clock,
//                          the same value the transmitter uses.
//   rx_state_t           : receiver FSM state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
//   Two-flop synchroniser for a single asynchronous input.
//   Ports:
//     clk : destination clock
//     rst : asynchronous active-low reset; both flops load RESET_VAL
//     d   : asynchronous input
//     q   : synchronised output, two clocks of latency
//   RESET_VAL lets the caller pick the idle level of the line so that
//   reset release never looks like an edge.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 UART receiver: start(0), 8 data bits LSB first, stop(1).
//   Each bit is sampled at its midpoint, timed from the detected start edge.
//   Ports:
//     clk        : system clock, rising edge
//     rst        : asynchronous active-low reset
//     rx         : serial line from the pin, asynchronous, idles high
//     data       : last good byte; holds until the next good frame
//     data_valid : one-cycle pulse, data valid in the same cycle
//     frame_err  : one-cycle pulse when the stop bit samples low
//     rx_busy    : high from start detection until IDLE or BREAK_WAIT
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | line idle, waiting for rx_s low
//   START      | counting to start-bit midpoint, confirm still low
//   DATA       | sampling 8 data bits, one per CLKS_PER_BIT
//   STOP       | sampling stop bit; good -> data_valid, bad -> frame_err
//   BREAK_WAIT | after a framing error, wait for the line to go high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  rx_state_t     state;
  logic          rx_s;
  logic [CW-1:0] clk_c;
  logic [2:0]    bit_c;
  logic [7:0]    shreg;

  // Reset to 1 so the synchroniser reads as an idle line after reset.
  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clk_c      <= '0;
      bit_c      <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_c   <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (clk_c == HALF_LAST) begin
            clk_c <= '0;
            if (!rx_s) begin
              state <= DATA;
              bit_c <= '0;
            end else begin
              // Line went back high before mid-bit: a glitch, not a frame.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_c <= clk_c + CNT_ONE;
          end
        end

        DATA: begin
          if (clk_c == BIT_LAST) begin
            // Right shift so the first (LSB) bit ends up in bit 0.
            shreg <= {rx_s, shreg[7:1]};
            clk_c <= '0;
            bit_c <= bit_c + 3'd1;
            if (bit_c == 3'd7) begin
              state <= STOP;
            end
          end else begin
            clk_c <= clk_c + CNT_ONE;
          end
        end

        STOP: begin
          if (clk_c == BIT_LAST) begin
            clk_c   <= '0;
            rx_busy <= 1'b0;
            if (rx_s) begin
              data       <= shreg;
              data_valid <= 1'b1;
              // Leaving at stop mid-bit lets a back-to-back start edge be caught.
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK_WAIT;
            end
          end else begin
            clk_c <= clk_c + CNT_ONE;
          end
        end

        BREAK_WAIT: begin
          // A held-low line must not decode as a stream of 0x00 frames.
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          clk_c   <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
module tb_uart_rx_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx_a, rx_b, rx_c;

  logic [7:0] data_a, data_b, data_c;
  logic       v_a, v_b, v_c;
  logic       f_a, f_b, f_c;
  logic       busy_a, busy_b, busy_c;

  uart_rx_core dut_def (
    .clk(clk), .rst(rst), .rx(rx_a),
    .data(data_a), .data_valid(v_a), .frame_err(f_a), .rx_busy(busy_a)
  );

  uart_rx_core #(.CLKS_PER_BIT(8)) dut_8 (
    .clk(clk), .rst(rst), .rx(rx_b),
    .data(data_b), .data_valid(v_b), .frame_err(f_b), .rx_busy(busy_b)
  );

  uart_rx_core #(.CLKS_PER_BIT(16)) dut_16 (
    .clk(clk), .rst(rst), .rx(rx_c),
    .data(data_c), .data_valid(v_c), .frame_err(f_c), .rx_busy(busy_c)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int nv_a = 0, nv_b = 0, nv_c = 0;
  int nf_a = 0, nf_b = 0, nf_c = 0;
  int overlap = 0;
  int tv_a = 0;
  int tlast_b = 0, tprev_b = 0;
  logic [7:0] dlast_b = 8'h00, dprev_b = 8'h00;
  logic busy_seen_b = 1'b0;

  always @(negedge clk) begin
    if (v_a) begin nv_a = nv_a + 1; tv_a = cyc; end
    if (v_b) begin
      nv_b = nv_b + 1;
      tprev_b = tlast_b; tlast_b = cyc;
      dprev_b = dlast_b; dlast_b = data_b;
    end
    if (v_c) nv_c = nv_c + 1;
    if (f_a) nf_a = nf_a + 1;
    if (f_b) nf_b = nf_b + 1;
    if (f_c) nf_c = nf_c + 1;
    if ((v_a && f_a) || (v_b && f_b) || (v_c && f_c)) overlap = overlap + 1;
    if (busy_b) busy_seen_b = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Ideal 8N1 transmitter; the line is left at the stop-bit level.
  task automatic send(input int sel, input logic [7:0] b, input logic stopb, input real bit_ns);
    set_rx(sel, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      #(bit_ns);
    end
    set_rx(sel, stopb);
    #(bit_ns);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stopb;
    logic [7:0] exp_data;
    int         exp_v;
    int         exp_f;
  } vec_t;

  vec_t tbl[5];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    int v0, f0, t_fall;

    tbl[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
    tbl[1] = '{8'h01, 1'b1, 8'h01, 1, 0};
    tbl[2] = '{8'h80, 1'b1, 8'h80, 1, 0};
    tbl[3] = '{8'h3C, 1'b0, 8'h80, 0, 1};
    tbl[4] = '{8'hC7, 1'b1, 8'hC7, 1, 0};

    rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", int'(data_b), 0);
    chk("reset_valid", int'(v_b), 0);
    chk("reset_ferr", int'(f_b), 0);
    chk("reset_busy", int'({busy_a, busy_b, busy_c}), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Default divisor: 0xA5, latency from rx falling edge.
    align();
    t_fall = cyc;
    v0 = nv_a;
    send(0, 8'hA5, 1'b1, 4340.0);
    repeat (5) @(negedge clk);
    chk("def_valid_count", nv_a - v0, 1);
    chk("def_data", int'(data_a), 8'hA5);
    chk("def_ferr_count", nf_a, 0);
    chk_range("def_latency", tv_a - t_fall, 4120, 4130);

    // Table-driven single frames at 8 clocks per bit.
    for (int i = 0; i < 5; i++) begin
      v0 = nv_b; f0 = nf_b;
      align();
      send(1, tbl[i].b, tbl[i].stopb, 80.0);
      rx_b = 1'b1;
      repeat (10) @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), nv_b - v0, tbl[i].exp_v);
      chk($sformatf("tbl%0d_ferr", i), nf_b - f0, tbl[i].exp_f);
      chk($sformatf("tbl%0d_data", i), int'(data_b), int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_busy", i), int'(busy_b), 0);
    end

    // Back-to-back 0x00 then 0xFF, no idle gap.
    v0 = nv_b;
    align();
    send(1, 8'h00, 1'b1, 80.0);
    send(1, 8'hFF, 1'b1, 80.0);
    repeat (10) @(negedge clk);
    chk("b2b_valid_count", nv_b - v0, 2);
    chk("b2b_first", int'(dprev_b), 8'h00);
    chk("b2b_second", int'(dlast_b), 8'hFF);
    chk("b2b_spacing", tlast_b - tprev_b, 80);

    // Two-clock glitch: busy pulses, nothing decoded.
    v0 = nv_b; f0 = nf_b;
    repeat (3) @(negedge clk);
    busy_seen_b = 1'b0;
    align();
    rx_b = 1'b0;
    #20;
    rx_b = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy_seen", int'(busy_seen_b), 1);
    chk("glitch_busy_end", int'(busy_b), 0);
    chk("glitch_valid", nv_b - v0, 0);
    chk("glitch_ferr", nf_b - f0, 0);
    chk("glitch_data", int'(data_b), 8'hFF);

    // Framing error followed by a held-low break, then a good frame.
    v0 = nv_b; f0 = nf_b;
    align();
    send(1, 8'h3C, 1'b0, 80.0);
    repeat (50) @(negedge clk);
    chk("break_busy_low", int'(busy_b), 0);
    rx_b = 1'b1;
    repeat (10) @(negedge clk);
    chk("break_ferr_count", nf_b - f0, 1);
    chk("break_valid_count", nv_b - v0, 0);
    chk("break_data_kept", int'(data_b), 8'hFF);
    align();
    send(1, 8'h81, 1'b1, 80.0);
    repeat (10) @(negedge clk);
    chk("after_break_valid", nv_b - v0, 1);
    chk("after_break_data", int'(data_b), 8'h81);

    // Reset during data bit 4; upper nibble of 0xF3 keeps the line high after release.
    v0 = nv_b; f0 = nf_b;
    align();
    fork
      send(1, 8'hF3, 1'b1, 80.0);
      begin
        #420;
        rst = 1'b0;
        #5;
        chk("midrst_data", int'(data_b), 0);
        chk("midrst_def_data", int'(data_a), 0);
        chk("midrst_valid", int'(v_b), 0);
        chk("midrst_ferr", int'(f_b), 0);
        chk("midrst_busy", int'(busy_b), 0);
        #25;
        rst = 1'b1;
      end
    join
    rx_b = 1'b1;
    repeat (10) @(negedge clk);
    chk("aborted_valid", nv_b - v0, 0);
    chk("aborted_ferr", nf_b - f0, 0);
    align();
    send(1, 8'h5A, 1'b1, 80.0);
    repeat (10) @(negedge clk);
    chk("post_rst_valid", nv_b - v0, 1);
    chk("post_rst_data", int'(data_b), 8'h5A);

    // Baud tolerance at 16 clocks per bit, transmitter 4% fast then 4% slow.
    v0 = nv_c;
    align();
    send(2, 8'hC3, 1'b1, 153.6);
    repeat (10) @(negedge clk);
    chk("fast_valid", nv_c - v0, 1);
    chk("fast_data", int'(data_c), 8'hC3);
    align();
    send(2, 8'h3C, 1'b1, 153.6);
    repeat (10) @(negedge clk);
    chk("fast2_data", int'(data_c), 8'h3C);
    v0 = nv_c;
    align();
    send(2, 8'hC3, 1'b1, 166.4);
    repeat (10) @(negedge clk);
    chk("slow_valid", nv_c - v0, 1);
    chk("slow_data", int'(data_c), 8'hC3);
    chk("tol_ferr", nf_c, 0);

    chk("valid_ferr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
8N1 UART receiver. It is the receive-side counterpart of the team's 8N1 UART transmitter, which idles high, sends start(0), data LSB-first, then stop(1). It synchronises the asynchronous serial line, detects the start bit and samples each bit at its midpoint. It then presents the byte with a one-cycle valid pulse and flags framing errors. It sits between the FPGA pin and the byte-level host logic. The default timing is 115200 baud from a 50 MHz clock.

Parameters:
CLKS_PER_BIT, 434, clocks per bit period (50 MHz / 115200). Must be >= 4.
HALF_BIT, CLKS_PER_BIT/2, clocks from start-edge detection to the start-bit midpoint check.

Ports:
clk  input  1  system clock; all state on the rising edge.
rst  input  1  asynchronous, active-low reset. Assertion (0) clears all state immediately; release is used synchronously.
rx  input  1  serial line from the pin; asynchronous to clk; idles high.
data  output  8  last received byte, LSB = first data bit. Holds until the next good frame.
data_valid  output  1  one-cycle pulse; data is valid in the same cycle.
frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
rx_busy  output  1  high from start-edge detection until return to IDLE or BREAK_WAIT.

Behaviour:
- Reset (rst=0): data=8'h00, data_valid=0, frame_err=0, rx_busy=0, state=IDLE, counters=0. Synchroniser flops are set to 1 (line idle).
- Synchroniser: rx passes through two flops to give rx_s (2-cycle latency). All decisions use rx_s only.
- Bit counter clk_c has width $clog2(CLKS_PER_BIT). Bit index bit_c is 3 bits (0..7).
- IDLE:
  - rx_s==0 -> START, clk_c=0, rx_busy=1.
  - Otherwise remain in IDLE.
- START: clk_c increments each cycle. When clk_c==HALF_BIT-1:
  - if rx_s==0 -> DATA, clk_c=0, bit_c=0;
  - if rx_s==1 -> IDLE, rx_busy=0. This rejects a glitch or false start, and no pulse is produced.
- DATA: when clk_c==CLKS_PER_BIT-1:
  - shift rx_s into the shift register MSB (right shift), so the first data bit ends in bit 0;
  - clk_c=0, bit_c increments;
  - after the 8th sample (bit_c==7) -> STOP.
  - Otherwise clk_c increments.
- STOP: when clk_c==CLKS_PER_BIT-1, sample rx_s:
  - if 1: data<=shift register, data_valid=1 for the next cycle only, -> IDLE, rx_busy=0;
  - if 0: frame_err=1 for one cycle, data unchanged, data_valid stays 0, -> BREAK_WAIT.
- BREAK_WAIT: rx_busy=0. Stay until rx_s==1, then -> IDLE. This stops a held-low line (break) from being decoded as repeated 0x00 frames.
- Latency: the stop sample occurs HALF_BIT-1 + 9*CLKS_PER_BIT clocks after START entry. START entry is 3 clocks after the rx falling edge. data_valid is high on the following cycle (≈4125 clocks after the rx edge at default parameters).
- Back-to-back frames: returning to IDLE at stop mid-bit means a start edge arriving directly after the stop bit is caught. No idle gap is required.
- Outputs data_valid and frame_err are never high in the same cycle.
- Mid-frame rst assertion aborts the frame; after release the block waits in IDLE for a fresh falling edge.

Decomposition:
- Shared package uart_pkg holds:
  - localparam CLKS_PER_BIT_DEFAULT=434, the same baud constant the transmitter uses;
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK_WAIT}.
- One sub-module, uart_sync2: a two-flop synchroniser with a reset value parameter, reusable for other async inputs.

Test Plan:
- Default parameters; TX model sends 8'hA5 at 434 clk/bit -> exactly one data_valid pulse, data=8'hA5, frame_err never high, pulse 4120..4130 clocks after the rx falling edge.
- CLKS_PER_BIT=8; frames 8'h00 then 8'hFF back-to-back with no idle gap -> two data_valid pulses, data=8'h00 then 8'hFF, pulses spaced 80 clocks apart.
- CLKS_PER_BIT=8; rx pulsed low for 2 clocks -> rx_busy rises then falls, no data_valid, no frame_err, data keeps its previous value.
- CLKS_PER_BIT=8; frame 8'h3C with stop bit 0, then rx held low 50 clocks, then high -> one frame_err pulse, no data_valid, data unchanged, no further pulses while low, next good frame 8'h81 decoded correctly.
- CLKS_PER_BIT=8; assert rst=0 during data bit 4, release, then send 8'h5A -> all outputs 0 during reset, the aborted frame gives no pulse, then data=8'h5A with one data_valid pulse.
- Tolerance, CLKS_PER_BIT=16; TX model running 4% fast and 4% slow sends 8'hC3 -> data=8'hC3 decoded in both cases.
